// File: rtl/unified_mem_arbiter.sv
// Arbiter sharing one fixed-latency 64-bit memory port between the IF and MEM stages.
// Define ARB_ROUND_ROBIN_EN for alternating contested arbitration instead of data priority.
module unified_mem_arbiter #(
  parameter int unsigned ADDR_W     = 64,
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned MEM_LAT    = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_if,
  output logic              stall_mem
);

  localparam int unsigned LAT_W = $clog2(MEM_LAT + 1);
  localparam int unsigned STV_W = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t            state, state_nxt;
  logic [LAT_W-1:0]  lat_cnt;
  logic              own_d;
  logic              lat_we;
  logic              if_pend, d_pend;
  logic              start_c, done_c, if_win_c;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_d;

  // Contested: alternate, data first after reset
  assign if_win_c = if_req & (~d_req | last_d);

  always_ff @(posedge clk) begin
    if (reset)        last_d <= 1'b0;
    else if (start_c) last_d <= ~if_win_c;
  end
`else
  logic [STV_W-1:0] starve_cnt;

  // Contested: data wins unless IF has lost STARVE_MAX times in a row
  assign if_win_c = if_req & (~d_req | (starve_cnt == STV_W'(STARVE_MAX)));

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (start_c) begin
      if (if_win_c)
        starve_cnt <= '0;
      else if (if_req && (starve_cnt != STV_W'(STARVE_MAX)))
        starve_cnt <= starve_cnt + STV_W'(1);
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start_c   = 1'b0;
    done_c    = 1'b0;
    case (state)
      S_IDLE: begin
        if (if_req || d_req) begin
          state_nxt = S_ISSUE;
          start_c   = 1'b1;
        end
      end
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT: begin
        if (lat_cnt == LAT_W'(1)) begin
          state_nxt = S_RESP;
          done_c    = 1'b1;
        end
      end
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Transaction latch, strobes and read-data capture
  always_ff @(posedge clk) begin
    if (reset) begin
      if_gnt    <= 1'b0;
      d_gnt     <= 1'b0;
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      own_d     <= 1'b0;
      lat_we    <= 1'b0;
      lat_cnt   <= '0;
      if_pend   <= 1'b0;
      d_pend    <= 1'b0;
    end else begin
      if_gnt    <= 1'b0;
      d_gnt     <= 1'b0;
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      if (start_c) begin
        own_d     <= ~if_win_c;
        lat_we    <= ~if_win_c & d_we;
        mem_addr  <= if_win_c ? if_addr : d_addr;
        mem_wdata <= if_win_c ? '0 : d_wdata;
        if_gnt    <= if_win_c;
        d_gnt     <= ~if_win_c;
        mem_en    <= 1'b1;
        mem_we    <= ~if_win_c & d_we;
      end
      if (state == S_ISSUE)     lat_cnt <= LAT_W'(MEM_LAT);
      else if (state == S_WAIT) lat_cnt <= lat_cnt - LAT_W'(1);
      if (done_c) begin
        if (!own_d)
          if_rdata <= mem_addr[2] ? mem_rdata[32 +: 32] : mem_rdata[0 +: 32];
        else if (!lat_we)
          d_rdata <= mem_rdata;
        if_rvalid <= ~own_d;
        d_rvalid  <= own_d;
      end
      if (if_gnt)         if_pend <= 1'b1;
      else if (if_rvalid) if_pend <= 1'b0;
      if (d_gnt)          d_pend  <= 1'b1;
      else if (d_rvalid)  d_pend  <= 1'b0;
    end
  end

  assign stall_if  = (if_req | if_pend) & ~if_rvalid;
  assign stall_mem = (d_req | d_pend) & ~d_rvalid;

endmodule
